// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage pipeline controller for a 5-stage RV32 subset core.
// Decodes the IF/ID instruction, selects the immediate format, tracks the
// EX/MEM destination shadows, inserts load-use / branch-operand stalls and
// flushes the front end on a taken BEQ.
// Optional feature macro: HAZARD_STATS_EN (adds stall/flush counters).
module hazard_ctrl #(
  parameter int REG_AW = 5
`ifdef HAZARD_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        instr_valid_i,
  input  logic        branch_taken_i,
  input  logic        ext_stall_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic        pc_src_o,
  output logic [2:0]  imm_sel_o
`ifdef HAZARD_STATS_EN
  , output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
`endif
);

  localparam logic [2:0] IMM_NONE  = 3'd0;
  localparam logic [2:0] IMM_I     = 3'd1;
  localparam logic [2:0] IMM_SHAMT = 3'd2;
  localparam logic [2:0] IMM_S     = 3'd3;
  localparam logic [2:0] IMM_B     = 3'd4;

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t r_state, w_state_next;

  // EX and MEM destination shadows
  logic [REG_AW-1:0] r_ex_rd, r_mem_rd;
  logic              r_ex_we, r_ex_load, r_ex_beq;
  logic              r_mem_we, r_mem_load;

  // ID decode results
  logic [9:0]        w_key;
  logic [REG_AW-1:0] w_rs1, w_rs2, w_rd;
  logic              w_use1, w_use2, w_wr, w_is_load, w_is_beq;
  logic [2:0]        w_imm;
  logic              w_unused;

  assign w_key    = {instr_i[14:12], instr_i[6:0]};
  assign w_rs1    = instr_i[15 +: REG_AW];
  assign w_rs2    = instr_i[20 +: REG_AW];
  assign w_rd     = instr_i[7 +: REG_AW];
  assign w_unused = &{1'b0, instr_i[31:25]};

  // Instruction decode; an invalid slot decodes as a NOP
  always_comb begin
    w_use1    = 1'b0;
    w_use2    = 1'b0;
    w_wr      = 1'b0;
    w_is_load = 1'b0;
    w_is_beq  = 1'b0;
    w_imm     = IMM_NONE;
    if (instr_valid_i) begin
      if (w_key[6:0] == 7'b0110011) begin            // R-type, any funct3
        w_use1 = 1'b1; w_use2 = 1'b1; w_wr = 1'b1;
      end else begin
        case (w_key)
          {3'b000, 7'b0010011}: begin w_use1 = 1'b1; w_wr = 1'b1; w_imm = IMM_I; end      // ADDI
          {3'b101, 7'b0010011}: begin w_use1 = 1'b1; w_wr = 1'b1; w_imm = IMM_SHAMT; end  // SRAI
          {3'b010, 7'b0000011}: begin w_use1 = 1'b1; w_wr = 1'b1; w_is_load = 1'b1; w_imm = IMM_I; end // LW
          {3'b010, 7'b0100011}: begin w_use1 = 1'b1; w_use2 = 1'b1; w_imm = IMM_S; end    // SW
          {3'b000, 7'b1100011}: begin w_use1 = 1'b1; w_use2 = 1'b1; w_is_beq = 1'b1; w_imm = IMM_B; end // BEQ
          default: ;
        endcase
      end
    end
  end

  // Hazard detection against the shadows (x0 never matches since we=0 for rd=0)
  logic w_ex_hit, w_mem_hit, w_h_lu, w_h_ba, w_h_bl, w_stall, w_taken;

  assign w_ex_hit  = r_ex_we  & ((w_use1 & (w_rs1 != '0) & (w_rs1 == r_ex_rd)) |
                                 (w_use2 & (w_rs2 != '0) & (w_rs2 == r_ex_rd)));
  assign w_mem_hit = r_mem_we & ((w_use1 & (w_rs1 != '0) & (w_rs1 == r_mem_rd)) |
                                 (w_use2 & (w_rs2 != '0) & (w_rs2 == r_mem_rd)));
  assign w_h_lu  = w_ex_hit & r_ex_load;
  assign w_h_ba  = w_is_beq & w_ex_hit & ~r_ex_load;
  assign w_h_bl  = w_is_beq & ((w_ex_hit & r_ex_load) | (w_mem_hit & r_mem_load));
  assign w_stall = w_h_lu | w_h_ba | w_h_bl;
  assign w_taken = r_ex_beq & branch_taken_i;

  // Next-state and pipeline control; reset, then ext stall, then branch, then hazard
  always_comb begin
    w_state_next  = r_state;
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pc_src_o      = 1'b0;
    if (rst_i) begin
      w_state_next  = ST_RUN;
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (ext_stall_i) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_taken) begin
            pc_src_o      = 1'b1;
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
            w_state_next  = ST_FLUSH;
          end else if (w_stall) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
          end
        end
        default: w_state_next = ST_RUN;  // FLUSH: IF/ID holds a NOP, run normally
      endcase
    end
  end

  assign imm_sel_o = rst_i ? IMM_NONE : w_imm;

  // State register and shadow pipeline; both hold while memory is busy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_RUN;
      r_ex_rd    <= '0;
      r_ex_we    <= 1'b0;
      r_ex_load  <= 1'b0;
      r_ex_beq   <= 1'b0;
      r_mem_rd   <= '0;
      r_mem_we   <= 1'b0;
      r_mem_load <= 1'b0;
    end else if (!ext_stall_i) begin
      r_state    <= w_state_next;
      r_mem_rd   <= r_ex_rd;
      r_mem_we   <= r_ex_we;
      r_mem_load <= r_ex_load;
      if (idex_bubble_o) begin
        r_ex_rd   <= '0;
        r_ex_we   <= 1'b0;
        r_ex_load <= 1'b0;
        r_ex_beq  <= 1'b0;
      end else begin
        r_ex_rd   <= w_rd;
        r_ex_we   <= w_wr & (w_rd != '0);
        r_ex_load <= w_is_load;
        r_ex_beq  <= w_is_beq;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_stall_ev, w_flush_ev;

  assign w_stall_ev = ~rst_i & ~ext_stall_i & idex_bubble_o & ~ifid_flush_o;
  assign w_flush_ev = ~rst_i & ~ext_stall_i & ifid_flush_o;

  // Saturating statistics counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_ev && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_ev && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl. Control outputs are compared as the
// packed vector {pc_write, ifid_write, ifid_flush, idex_bubble, pc_src}.
module tb_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] instr_i;
  logic        instr_valid_i;
  logic        branch_taken_i;
  logic        ext_stall_i;
  logic        pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pc_src_o;
  logic [2:0]  imm_sel_o;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_o, flush_cnt_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [4:0] C_NORM   = 5'b11000;
  localparam logic [4:0] C_STALL  = 5'b00010;
  localparam logic [4:0] C_TAKEN  = 5'b11111;
  localparam logic [4:0] C_FROZEN = 5'b00000;
  localparam logic [4:0] C_RESET  = 5'b00110;

  localparam logic [31:0] LW_X5   = 32'h0000A283;  // lw   x5,0(x1)
  localparam logic [31:0] ADDI_65 = 32'h00128313;  // addi x6,x5,1
  localparam logic [31:0] ADDI_50 = 32'h00100293;  // addi x5,x0,1
  localparam logic [31:0] BEQ_50  = 32'h00028063;  // beq  x5,x0,0
  localparam logic [31:0] NOP     = 32'h00000013;  // addi x0,x0,0
  localparam logic [31:0] LW_X0   = 32'h0000A003;  // lw   x0,0(x1)
  localparam logic [31:0] ADDI_60 = 32'h00100313;  // addi x6,x0,1
  localparam logic [31:0] SRAI_5  = 32'h4012D293;  // srai x5,x5,1
  localparam logic [31:0] SW_5    = 32'h0050A023;  // sw   x5,0(x1)

  always #5 clk_i = ~clk_i;

  hazard_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .instr_i        (instr_i),
    .instr_valid_i  (instr_valid_i),
    .branch_taken_i (branch_taken_i),
    .ext_stall_i    (ext_stall_i),
    .pc_write_o     (pc_write_o),
    .ifid_write_o   (ifid_write_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_bubble_o  (idex_bubble_o),
    .pc_src_o       (pc_src_o),
    .imm_sel_o      (imm_sel_o)
`ifdef HAZARD_STATS_EN
    , .stall_cnt_o  (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are already applied (1 time unit after an edge); settle, compare, advance one cycle
  task automatic step(input string tag, input logic [4:0] exp_ctl, input logic [2:0] exp_imm);
    logic [4:0] ctl;
    #3;
    ctl = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pc_src_o};
    chk({tag, ".ctl"}, {11'd0, ctl}, {11'd0, exp_ctl});
    chk({tag, ".imm"}, {13'd0, imm_sel_o}, {13'd0, exp_imm});
    $display("step %-12s instr=%08h v=%0d bt=%0d xs=%0d rst=%0d ctl=%05b imm=%0d",
             tag, instr_i, instr_valid_i, branch_taken_i, ext_stall_i, rst_i, ctl, imm_sel_o);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; instr_i = 32'h0; instr_valid_i = 1'b0;
    branch_taken_i = 1'b0; ext_stall_i = 1'b0;
    #1;
    step("reset", C_RESET, 3'd0);

    // Load-use: one bubble, imm I throughout
    rst_i = 1'b0; instr_i = LW_X5; instr_valid_i = 1'b1;
    step("lw", C_NORM, 3'd1);
    instr_i = ADDI_65;
    step("lu_stall", C_STALL, 3'd1);
    step("lu_go", C_NORM, 3'd1);

    // ALU op then BEQ: one stall
    instr_i = ADDI_50;
    step("addi_x5", C_NORM, 3'd1);
    instr_i = BEQ_50;
    step("ba_stall", C_STALL, 3'd4);
    step("ba_go", C_NORM, 3'd4);

    // BEQ now in EX, taken
    instr_i = NOP; branch_taken_i = 1'b1;
    step("taken", C_TAKEN, 3'd1);
    instr_i = 32'h0; instr_valid_i = 1'b0; branch_taken_i = 1'b0;
    step("flush_st", C_NORM, 3'd0);

    // LW then BEQ: two stalls
    instr_i = LW_X5; instr_valid_i = 1'b1;
    step("lw2", C_NORM, 3'd1);
    instr_i = BEQ_50;
    step("bl_stall1", C_STALL, 3'd4);
    step("bl_stall2", C_STALL, 3'd4);
    step("bl_go", C_NORM, 3'd4);

    // Taken branch frozen by ext stall for 3 cycles, acted on the 4th
    instr_i = NOP; branch_taken_i = 1'b1; ext_stall_i = 1'b1;
    step("frz1", C_FROZEN, 3'd1);
    step("frz2", C_FROZEN, 3'd1);
    step("frz3", C_FROZEN, 3'd1);
    ext_stall_i = 1'b0;
    step("frz_taken", C_TAKEN, 3'd1);
    instr_i = 32'h0; instr_valid_i = 1'b0; branch_taken_i = 1'b0;
    step("flush_st2", C_NORM, 3'd0);

    // LW to x0 creates no hazard
    instr_i = LW_X0; instr_valid_i = 1'b1;
    step("lw_x0", C_NORM, 3'd1);
    instr_i = ADDI_60;
    step("addi_x0src", C_NORM, 3'd1);

    // Immediate formats
    instr_i = SRAI_5;
    step("srai", C_NORM, 3'd2);
    instr_i = SW_5;
    step("sw", C_NORM, 3'd3);

    // Invalid slot: decodes as NOP even though it names a loaded register
    instr_i = LW_X5;
    step("lw3", C_NORM, 3'd1);
    instr_i = ADDI_65; instr_valid_i = 1'b0;
    step("invalid", C_NORM, 3'd0);

    // Reset during the second cycle of a LW->BEQ stall
    instr_i = LW_X5; instr_valid_i = 1'b1;
    step("lw4", C_NORM, 3'd1);
    instr_i = BEQ_50;
    step("rs_stall1", C_STALL, 3'd4);
    rst_i = 1'b1;
    step("rs_reset", C_RESET, 3'd0);
    rst_i = 1'b0;
`ifdef HAZARD_STATS_EN
    chk("stall_cnt_rst", stall_cnt_o, 16'd0);
    chk("flush_cnt_rst", flush_cnt_o, 16'd0);
`endif
    step("rs_clean", C_NORM, 3'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
